// File: rtl/mod_mult_pkg.sv
// Shared definitions for the sequential modular multiplier.
//   MaxBits   : operand / modulus width
//   MaxReg    : log2(MaxBits); the bit counter is MaxReg+1 bits wide
//   P256      : NIST P-256 prime, available to benches and point arithmetic
//   state_e   : FSM state encoding (IDLE = 0, RUN = 1)
package mod_mult_pkg;

    localparam int unsigned MaxBits = 256;
    localparam int unsigned MaxReg  = 8;
    localparam int unsigned CountW  = MaxReg + 1;

    localparam logic [CountW-1:0] CountInit = CountW'(MaxBits - 1);

    localparam logic [MaxBits-1:0] P256 =
        256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/mod_mult_step.sv
// One MSB-first interleaved step: p_o = (2*p_i [+ a_i if bit_i]) mod n_i.
// Ports:
//   p_i   : running partial product, MaxBits+1 bits, < n_i
//   a_i   : multiplicand, < n_i
//   n_i   : modulus
//   bit_i : current multiplier bit
//   p_o   : next partial product, < n_i when inputs meet the preconditions
module mod_mult_step
    import mod_mult_pkg::*;
(
    input  logic [MaxBits:0]   p_i,
    input  logic [MaxBits-1:0] a_i,
    input  logic [MaxBits-1:0] n_i,
    input  logic               bit_i,
    output logic [MaxBits:0]   p_o
);

    logic [MaxBits:0] n_ext;
    logic [MaxBits:0] t_dbl;
    logic [MaxBits:0] t_add;

    assign n_ext = {1'b0, n_i};

    always_comb begin
        // p < n fits in MaxBits bits, so the doubling cannot overflow MaxBits+1 bits.
        t_dbl = {p_i[MaxBits-1:0], 1'b0};
        if (t_dbl >= n_ext) begin
            t_dbl = t_dbl - n_ext;
        end

        t_add = t_dbl;
        if (bit_i) begin
            t_add = t_dbl + {1'b0, a_i};
        end
        if (t_add >= n_ext) begin
            t_add = t_add - n_ext;
        end

        p_o = t_add;
    end

endmodule

// File: rtl/mod_mult.sv
// Sequential modular multiplier: o_result = i_a * i_b mod i_n, one multiplier bit per cycle,
// fixed latency of MaxBits cycles from accepted start to the o_finished pulse.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-low reset
//   i_start    : request, sampled only while idle
//   i_n        : modulus (>= 2)
//   i_a, i_b   : operands (< i_n)
//   o_result   : registered result, updated only on completion
//   o_finished : registered one-cycle completion pulse
module mod_mult
    import mod_mult_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [MaxBits-1:0] i_n,
    input  logic [MaxBits-1:0] i_a,
    input  logic [MaxBits-1:0] i_b,
    output logic [MaxBits-1:0] o_result,
    output logic               o_finished
);

    state_e              state_q, state_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [MaxBits-1:0]  n_q, n_d;
    logic [MaxBits-1:0]  a_q, a_d;
    logic [MaxBits-1:0]  b_q, b_d;
    logic [MaxBits:0]    p_q, p_d;
    logic [MaxBits-1:0]  result_q, result_d;
    logic                finished_q, finished_d;
    logic [MaxBits:0]    p_next;

    mod_mult_step u_step (
        .p_i   (p_q),
        .a_i   (a_q),
        .n_i   (n_q),
        .bit_i (b_q[count_q[MaxReg-1:0]]),
        .p_o   (p_next)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        n_d        = n_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        result_d   = result_q;
        finished_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    n_d     = i_n;
                    a_d     = i_a;
                    b_d     = i_b;
                    p_d     = '0;
                    count_d = CountInit;
                    state_d = StRun;
                end
            end
            StRun: begin
                p_d = p_next;
                if (count_q == '0) begin
                    // Final p is < n, so dropping its MSB is lossless.
                    result_d   = p_next[MaxBits-1:0];
                    finished_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            n_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            result_q   <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            n_q        <= n_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            result_q   <= result_d;
            finished_q <= finished_d;
        end
    end

    assign o_result   = result_q;
    assign o_finished = finished_q;

endmodule

// File: tb/tb_mod_mult.sv
// Self-checking bench for mod_mult: directed vector table, random P-256 products checked
// against a wide-arithmetic reference, and hand-written reset / ignored-start / back-to-back
// sequences.
module tb_mod_mult;
    import mod_mult_pkg::*;

    logic               i_clk;
    logic               i_rst;
    logic               i_start;
    logic [MaxBits-1:0] i_n;
    logic [MaxBits-1:0] i_a;
    logic [MaxBits-1:0] i_b;
    logic [MaxBits-1:0] o_result;
    logic               o_finished;

    int errors = 0;
    int checks = 0;

    mod_mult dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_n        (i_n),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_result   (o_result),
        .o_finished (o_finished)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] n;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Wait for o_finished with a bound; returns cycles waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!o_finished && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    // Single operation: start pulse, latency, result and one-cycle pulse width.
    task automatic run_op(input string name, input logic [255:0] n, input logic [255:0] a,
                          input logic [255:0] b, input logic [255:0] exp);
        int lat;
        i_n     = n;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_n     = '0;
        i_a     = '0;
        i_b     = '0;
        wait_done(lat);
        chk({name, " latency"}, 256'(lat), 256'd256);
        chk({name, " result"}, o_result, exp);
        tick();
        chk({name, " pulse_fall"}, 256'(o_finished), 256'd0);
    endtask

    vec_t vecs[8];
    logic [255:0] p_m1;
    logic [255:0] two255;
    logic [511:0] wa, wb, wn, wprod;
    logic [255:0] ra, rb, rexp;
    int lat;

    initial begin
        p_m1   = P256 - 256'd1;
        two255 = 256'd1 << 255;

        vecs[0] = '{n: 256'd97, a: 256'd5,  b: 256'd20, exp: 256'd3};
        vecs[1] = '{n: 256'd97, a: 256'd0,  b: 256'd50, exp: 256'd0};
        vecs[2] = '{n: 256'd97, a: 256'd1,  b: 256'd50, exp: 256'd50};
        vecs[3] = '{n: 256'd97, a: 256'd50, b: 256'd1,  exp: 256'd50};
        vecs[4] = '{n: 256'd97, a: 256'd96, b: 256'd96, exp: 256'd1};
        vecs[5] = '{n: P256, a: p_m1, b: p_m1, exp: 256'd1};
        vecs[6] = '{n: P256, a: two255, b: 256'd2,
                    exp: 256'h00000000_fffffffe_ffffffff_ffffffff_ffffffff_00000000_00000000_00000001};
        // Divider round trip: 7 / 3 mod 11 = 6, so 6 * 3 mod 11 must give back 7.
        vecs[7] = '{n: 256'd11, a: 256'd6, b: 256'd3, exp: 256'd7};

        i_rst   = 1'b0;
        i_start = 1'b0;
        i_n     = '0;
        i_a     = '0;
        i_b     = '0;
        #12;
        chk("reset result", o_result, 256'd0);
        chk("reset finished", 256'(o_finished), 256'd0);
        i_rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Random P-256 round trips against an independent wide multiply/modulo.
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < 8; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            ra    = ra % P256;
            rb    = rb % P256;
            wa    = {256'd0, ra};
            wb    = {256'd0, rb};
            wn    = {256'd0, P256};
            wprod = (wa * wb) % wn;
            rexp  = wprod[255:0];
            run_op($sformatf("rand%0d", k), P256, ra, rb, rexp);
        end

        // Start pulsed mid-RUN must be ignored.
        i_n = 256'd97; i_a = 256'd5; i_b = 256'd20; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 50; c++) tick();
        i_n = 256'd97; i_a = 256'd96; i_b = 256'd96; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(lat);
        chk("midrun latency", 256'(lat + 51), 256'd256);
        chk("midrun result", o_result, 256'd3);
        tick();

        // Load a distinct result first so the reset clear is observable.
        run_op("pre_reset", 256'd97, 256'd50, 256'd1, 256'd50);
        i_n = 256'd97; i_a = 256'd96; i_b = 256'd96; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 99; c++) tick();
        i_rst = 1'b0;
        #2;
        chk("midrun reset result", o_result, 256'd0);
        chk("midrun reset finished", 256'(o_finished), 256'd0);
        tick();
        i_rst = 1'b1;
        lat = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (o_finished) lat++;
        end
        chk("no finish after reset", 256'(lat), 256'd0);
        run_op("post_reset", 256'd97, 256'd5, 256'd20, 256'd3);

        // Back-to-back with i_start held: completions 257 cycles apart.
        i_n = 256'd97; i_a = 256'd50; i_b = 256'd1; i_start = 1'b1;
        tick();
        i_a = 256'd5; i_b = 256'd20;
        wait_done(lat);
        chk("b2b first latency", 256'(lat), 256'd256);
        chk("b2b first result", o_result, 256'd50);
        lat = 0;
        begin
            int held_bad;
            held_bad = 0;
            tick();
            lat++;
            while (!o_finished && lat < 400) begin
                if (o_result !== 256'd50) held_bad++;
                tick();
                lat++;
            end
            chk("b2b result held", 256'(held_bad), 256'd0);
        end
        i_start = 1'b0;
        chk("b2b spacing", 256'(lat), 256'd257);
        chk("b2b second result", o_result, 256'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
